uart_tx_cfg: RTL and testbench

//  Parametrised UART transmitter; successor to the fixed-format TX used on the gsensor UART path.

---
 rtl/uart_tx_cfg.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// UART transmitter with runtime baud divisor, optional even/odd parity, 1/2 stop bits
// and a one-word holding buffer so consecutive frames can run with no idle gap.
module uart_tx_cfg #(
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned DIV_W     = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [DATA_BITS-1:0] i_data,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [DIV_W-1:0]     i_div,
   input  logic [1:0]           i_parity_mode,
   input  logic                 i_two_stop,
   output logic                 o_tx,
   output logic                 o_busy,
   output logic                 o_done
);

   localparam int unsigned CNT_W = $clog2(DATA_BITS + 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t               state_q, state_n;
   logic [DATA_BITS-1:0] buf_q, buf_n;
   logic                 buf_full_q, buf_full_n;
   logic [DATA_BITS-1:0] shift_q, shift_n;
   logic [DIV_W-1:0]     div_q, div_n;
   logic                 par_en_q, par_en_n;
   logic                 par_bit_q, par_bit_n;
   logic                 two_stop_q, two_stop_n;
   logic [DIV_W-1:0]     tick_q, tick_n;
   logic [CNT_W-1:0]     bit_q, bit_n;
   logic                 tx_q, busy_q, done_q;
   logic                 tx_c, done_c, take_c, tick_last_c;

   assign o_ready = ~buf_full_q;
   assign o_tx    = tx_q;
   assign o_busy  = busy_q;
   assign o_done  = done_q;

   assign tick_last_c = (tick_q == div_q - DIV_W'(1));

   // Next-state, datapath and line level; o_tx follows the state one cycle later
   always_comb begin
      state_n    = state_q;
      buf_n      = buf_q;
      buf_full_n = buf_full_q;
      shift_n    = shift_q;
      div_n      = div_q;
      par_en_n   = par_en_q;
      par_bit_n  = par_bit_q;
      two_stop_n = two_stop_q;
      tick_n     = tick_q;
      bit_n      = bit_q;
      tx_c       = 1'b1;
      done_c     = 1'b0;
      take_c     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (buf_full_q) begin
               take_c  = 1'b1;
               state_n = S_START;
            end
         end
         S_START: begin
            tx_c = 1'b0;
            if (tick_last_c) begin
               tick_n  = '0;
               bit_n   = '0;
               state_n = S_DATA;
            end else begin
               tick_n = tick_q + DIV_W'(1);
            end
         end
         S_DATA: begin
            tx_c = shift_q[0];
            if (tick_last_c) begin
               tick_n  = '0;
               shift_n = shift_q >> 1;
               if (bit_q == CNT_W'(DATA_BITS - 1)) begin
                  bit_n   = '0;
                  state_n = par_en_q ? S_PARITY : S_STOP;
               end else begin
                  bit_n = bit_q + CNT_W'(1);
               end
            end else begin
               tick_n = tick_q + DIV_W'(1);
            end
         end
         S_PARITY: begin
            tx_c = par_bit_q;
            if (tick_last_c) begin
               tick_n  = '0;
               state_n = S_STOP;
            end else begin
               tick_n = tick_q + DIV_W'(1);
            end
         end
         S_STOP: begin
            if (tick_last_c) begin
               tick_n = '0;
               if (two_stop_q && bit_q == '0) begin
                  bit_n = CNT_W'(1);
               end else begin
                  bit_n  = '0;
                  done_c = 1'b1;
                  if (buf_full_q) begin
                     take_c  = 1'b1;
                     state_n = S_START;
                  end else begin
                     state_n = S_IDLE;
                  end
               end
            end else begin
               tick_n = tick_q + DIV_W'(1);
            end
         end
         default: state_n = S_IDLE;
      endcase

      // Word and whole-frame config are captured together when the FSM takes the buffer
      if (take_c) begin
         shift_n    = buf_q;
         div_n      = (i_div == '0) ? DIV_W'(1) : i_div;
         par_en_n   = (i_parity_mode == 2'b01) || (i_parity_mode == 2'b10);
         par_bit_n  = (^buf_q) ^ i_parity_mode[1];
         two_stop_n = i_two_stop;
         buf_full_n = 1'b0;
      end

      if (i_valid && !buf_full_q) begin
         buf_n      = i_data;
         buf_full_n = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= S_IDLE;
         buf_q      <= '0;
         buf_full_q <= 1'b0;
         shift_q    <= '0;
         div_q      <= DIV_W'(1);
         par_en_q   <= 1'b0;
         par_bit_q  <= 1'b0;
         two_stop_q <= 1'b0;
         tick_q     <= '0;
         bit_q      <= '0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_n;
         buf_q      <= buf_n;
         buf_full_q <= buf_full_n;
         shift_q    <= shift_n;
         div_q      <= div_n;
         par_en_q   <= par_en_n;
         par_bit_q  <= par_bit_n;
         two_stop_q <= two_stop_n;
         tick_q     <= tick_n;
         bit_q      <= bit_n;
         tx_q       <= tx_c;
         busy_q     <= (state_q != S_IDLE);
         done_q     <= done_c;
      end
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Randomized bench for uart_tx_cfg: expected line waveform is built from the frame
// format (start, data LSB first, optional parity, stop bits) and compared per cycle.
module tb_uart_tx_cfg;

   localparam int unsigned DATA_BITS = 8;
   localparam int unsigned DIV_W     = 16;

   logic                 i_clk = 1'b0;
   logic                 i_rst_n;
   logic [DATA_BITS-1:0] i_data;
   logic                 i_valid;
   logic                 o_ready;
   logic [DIV_W-1:0]     i_div;
   logic [1:0]           i_parity_mode;
   logic                 i_two_stop;
   logic                 o_tx;
   logic                 o_busy;
   logic                 o_done;

   uart_tx_cfg #(.DATA_BITS(DATA_BITS), .DIV_W(DIV_W)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(i_data), .i_valid(i_valid),
      .o_ready(o_ready), .i_div(i_div), .i_parity_mode(i_parity_mode),
      .i_two_stop(i_two_stop), .o_tx(o_tx), .o_busy(o_busy), .o_done(o_done)
   );

   always #5 i_clk = ~i_clk;

   int unsigned cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   logic [DATA_BITS-1:0] words[$];
   int unsigned          cfg_div;
   logic [1:0]           cfg_pm;
   logic                 cfg_ts;
   logic                 exp_tx[$];
   logic                 exp_done[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
      else n_pass++;
   endtask

   // Reference frame: list of bit levels, each held for max(div,1) cycles
   function automatic void add_frame(input logic [DATA_BITS-1:0] d);
      logic        bits[$];
      int unsigned dv;
      dv = (cfg_div == 0) ? 1 : cfg_div;
      bits.push_back(1'b0);
      for (int i = 0; i < DATA_BITS; i++) bits.push_back(d[i]);
      if (cfg_pm == 2'b01) bits.push_back(($countones(d) % 2) == 1);
      if (cfg_pm == 2'b10) bits.push_back(($countones(d) % 2) == 0);
      bits.push_back(1'b1);
      if (cfg_ts) bits.push_back(1'b1);
      for (int b = 0; b < bits.size(); b++)
         for (int c = 0; c < int'(dv); c++) begin
            exp_tx.push_back(bits[b]);
            exp_done.push_back((b == bits.size() - 1) && (c == int'(dv) - 1));
         end
   endfunction

   task automatic run_stream(input bit cfg_wiggle);
      int unsigned acc_cyc = 0;
      int unsigned low_cyc = 0;
      bit          started = 0;
      exp_tx.delete();
      exp_done.delete();
      foreach (words[i]) add_frame(words[i]);
      fork
         begin
            foreach (words[w]) begin
               int t = 0;
               @(negedge i_clk);
               while (!o_ready && t < 1000) begin @(negedge i_clk); t++; end
               if (!o_ready) begin chk("ready_timeout", 0, 1); break; end
               i_data = words[w]; i_valid = 1'b1; i_div = DIV_W'(cfg_div);
               i_parity_mode = cfg_pm; i_two_stop = cfg_ts;
               @(posedge i_clk); #1;
               if (w == 0) acc_cyc = cyc;
               chk("ready_low", 32'(o_ready), 0);
               @(negedge i_clk);
               i_valid = 1'b0; i_data = DATA_BITS'($urandom);
               if (cfg_wiggle) begin
                  @(negedge i_clk);
                  i_div = DIV_W'($urandom_range(0, 9));
                  i_parity_mode = 2'($urandom);
                  i_two_stop = 1'($urandom);
               end
            end
         end
         begin
            int t = 0;
            @(negedge i_clk);
            while (o_tx !== 1'b0 && t < 1000) begin @(negedge i_clk); t++; end
            if (o_tx !== 1'b0) chk("start_timeout", 0, 1);
            else begin
               low_cyc = cyc; started = 1;
               for (int i = 0; i < exp_tx.size(); i++) begin
                  if (i > 0) @(negedge i_clk);
                  chk("tx", 32'(o_tx), 32'(exp_tx[i]));
                  chk("done", 32'(o_done), 32'(exp_done[i]));
                  chk("busy", 32'(o_busy), 1);
               end
               @(negedge i_clk);
               chk("idle_tx", 32'(o_tx), 1);
               chk("idle_busy", 32'(o_busy), 0);
               chk("idle_done", 32'(o_done), 0);
               chk("idle_ready", 32'(o_ready), 1);
            end
         end
      join
      if (started) chk("latency", low_cyc - acc_cyc, 2);
   endtask

   task automatic set_cfg(input int unsigned d, input logic [1:0] pm, input logic ts);
      cfg_div = d; cfg_pm = pm; cfg_ts = ts;
   endtask

   initial begin
      i_rst_n = 1'b0; i_data = '0; i_valid = 1'b0; i_div = '0;
      i_parity_mode = 2'b00; i_two_stop = 1'b0;
      repeat (3) @(negedge i_clk);
      chk("rst_tx", 32'(o_tx), 1);
      chk("rst_busy", 32'(o_busy), 0);
      chk("rst_done", 32'(o_done), 0);
      chk("rst_ready", 32'(o_ready), 1);
      i_rst_n = 1'b1;
      repeat (2) @(negedge i_clk);

      // Directed frames
      set_cfg(4, 2'b00, 1'b0); words = '{8'hA5}; run_stream(0);
      set_cfg(2, 2'b01, 1'b0); words = '{8'hA5}; run_stream(0);
      set_cfg(2, 2'b10, 1'b0); words = '{8'hA5}; run_stream(0);
      set_cfg(3, 2'b00, 1'b1); words = '{8'h00}; run_stream(0);
      set_cfg(4, 2'b00, 1'b0); words = '{8'h3C, 8'hC3}; run_stream(0);
      set_cfg(0, 2'b11, 1'b0); words = '{8'hFF}; run_stream(0);

      // Reset in the middle of the data bits
      @(negedge i_clk);
      i_data = 8'h55; i_valid = 1'b1; i_div = DIV_W'(4); i_parity_mode = 2'b00; i_two_stop = 1'b0;
      @(negedge i_clk);
      i_valid = 1'b0;
      repeat (14) @(negedge i_clk);
      chk("pre_rst_busy", 32'(o_busy), 1);
      i_rst_n = 1'b0;
      #1;
      chk("arst_tx", 32'(o_tx), 1);
      chk("arst_busy", 32'(o_busy), 0);
      chk("arst_ready", 32'(o_ready), 1);
      chk("arst_done", 32'(o_done), 0);
      repeat (2) @(negedge i_clk);
      i_rst_n = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge i_clk);
         chk("post_rst_done", 32'(o_done), 0);
         chk("post_rst_tx", 32'(o_tx), 1);
      end
      set_cfg(4, 2'b00, 1'b0); words = '{8'h55}; run_stream(0);

      // Random single frames with config disturbed while in flight
      for (int n = 0; n < 25; n++) begin
         set_cfg($urandom_range(0, 5), 2'($urandom), 1'($urandom));
         words = '{8'($urandom)};
         run_stream(1);
      end

      // Random back-to-back streams
      for (int n = 0; n < 5; n++) begin
         set_cfg($urandom_range(0, 4), 2'($urandom), 1'($urandom));
         words = '{8'($urandom), 8'($urandom), 8'($urandom)};
         run_stream(0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
